// File: rtl/rv32i_boot_ctrl.sv
// rv32i_boot_ctrl: boot and run controller for an RV32I core.
// Streams a program image into instruction memory, holds the core in reset
// for RST_HOLD cycles, releases it, then watches the PC for a halt address
// or a cycle budget.
// Optional feature macro: BOOT_WB_SIG_EN builds a rotate-xor signature of
// the core writeback bus; without it sig is tied to zero.
module rv32i_boot_ctrl #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RST_HOLD  = 2,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [31:0]          ld_data,
  input  logic                 ld_last,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 core_reset,
  input  logic [31:0]          pc,
  input  logic [31:0]          wb,
  input  logic [31:0]          halt_pc,
  input  logic [TIMEOUT_W-1:0] run_cycles,
  input  logic                 restart,
  output logic [ADDR_W:0]      word_count,
  output logic                 done,
  output logic                 timeout,
  output logic [31:0]          sig
);

  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
  localparam logic [ADDR_W:0]      WC_ONE    = (ADDR_W+1)'(1);
  localparam logic [TIMEOUT_W-1:0] TO_ONE    = TIMEOUT_W'(1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [TIMEOUT_W-1:0]   run_cnt;
  logic [TIMEOUT_W-1:0]   budget;
  logic                   accept;
  logic                   fill_last;
  logic                   hold_done;
  logic                   halt_hit;
  logic                   budget_hit;
  logic                   restart_take;

  // Status decode: beat handshake, hold completion, run-end conditions.
  always_comb begin
    accept       = ld_valid & ld_ready;
    // The beat being accepted occupies the last free slot.
    fill_last    = (word_count[ADDR_W-1:0] == '1);
    hold_done    = (state == S_HOLD) && (hold_cnt == HOLD_LAST);
    halt_hit     = (pc == halt_pc);
    budget_hit   = (budget != '0) && (run_cnt == (budget - TO_ONE));
    restart_take = restart && ((state == S_DONE) || (state == S_TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_LOAD: begin
        // Gated by reset_n so the handshake is dead while reset is held.
        ld_ready = reset_n;
        if (accept && (ld_last || fill_last)) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_done) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        core_reset = 1'b0;
        // Halt is tested first so it wins over a coincident timeout.
        if (halt_hit) begin
          state_nxt = S_DONE;
        end else if (budget_hit) begin
          state_nxt = S_TIMEOUT;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (restart) begin
          state_nxt = S_LOAD;
        end
      end
      S_TIMEOUT: begin
        timeout = 1'b1;
        if (restart) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // Load path: one registered memory write per accepted beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= ld_data;
        word_count <= word_count + WC_ONE;
      end else if (restart_take) begin
        word_count <= '0;
      end
    end
  end

  // Reset hold counter; runs only while in HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (state == S_HOLD) begin
      hold_cnt <= hold_cnt + HOLD_ONE;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Run cycle counter; budget latched on RUN entry so later changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
      budget  <= '0;
    end else if (hold_done) begin
      run_cnt <= '0;
      budget  <= run_cycles;
    end else if (state == S_RUN) begin
      run_cnt <= run_cnt + TO_ONE;
    end else if (restart_take) begin
      run_cnt <= '0;
    end
  end

`ifdef BOOT_WB_SIG_EN
  logic [31:0] sig_q;

  // Writeback signature: rotate left by one, fold in wb, every RUN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= '0;
    end else if (state == S_RUN) begin
      sig_q <= {sig_q[30:0], sig_q[31]} ^ wb;
    end else if (restart_take) begin
      sig_q <= '0;
    end
  end

  assign sig = sig_q;
`else
  logic unused_wb;

  assign unused_wb = ^wb;
  assign sig       = '0;
`endif

endmodule

// File: doc/rv32i_boot_ctrl.md
# rv32i_boot_ctrl

- Synthesizable boot and run controller that sits between an external load stream and the RV32I core's instruction memory and reset.
- Loads a program image word by word, holds the core in reset, then releases it.
- Monitors the core's PC for a halt address or a cycle-budget timeout, and reports completion.
- Replaces hard-coded memory initialisation and fixed-delay reset sequencing with a parametrised, restartable sequence.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- RST_HOLD, 2, cycles the core reset stays asserted after the last load write (≥1)
- TIMEOUT_W, 16, width of the run-cycle budget and counter

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load word present
- ld_ready  out  1  controller accepts a load word
- ld_data  in  32  instruction word
- ld_last  in  1  marks the final word of the image
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  write data
- core_reset  out  1  active-high reset to the core
- pc  in  32  core PC (byte address)
- wb  in  32  core WBout
- halt_pc  in  32  byte address that ends the run
- run_cycles  in  TIMEOUT_W  cycle budget; 0 = unlimited
- restart  in  1  single-cycle pulse; reload request from DONE or TIMEOUT
- word_count  out  ADDR_W+1  words written in the current load
- done  out  1  halt address reached (sticky)
- timeout  out  1  budget exhausted (sticky)
- sig  out  32  writeback signature

## Operation
States: LOAD, HOLD, RUN, DONE, TIMEOUT.

Reset (reset_n low, asynchronous) forces:
- state = LOAD
- ld_ready = 0 while reset_n is low
- imem_we = 0, imem_addr = 0, imem_wdata = 0, word_count = 0
- core_reset = 1, done = 0, timeout = 0, sig = 0
- all counters = 0

LOAD:
- ld_ready = 1.
- A beat is accepted when ld_valid & ld_ready. Accepted word goes to address word_count; word_count then increments.
- LOAD → HOLD when the accepted beat has ld_last = 1, or when word_count reaches 2^ADDR_W (memory full).
- At full, ld_ready drops and further words are refused.

HOLD:
- ld_ready = 0, core_reset = 1.
- Counts RST_HOLD cycles, then HOLD → RUN.

RUN:
- core_reset = 0.
- Cycle counter increments every cycle.
- pc == halt_pc → DONE.
- Else, if run_cycles ≠ 0 and counter == run_cycles − 1 → TIMEOUT.
- Halt takes priority over timeout when both occur in the same cycle.
- run_cycles is sampled at RUN entry; changes during RUN are ignored.

DONE / TIMEOUT:
- core_reset = 1 (core frozen); done or timeout is held at 1.
- restart → LOAD, clearing word_count, done, timeout, sig and the cycle counter.
- restart in any other state is ignored.
- reset_n low in any state aborts immediately to the reset values; partial memory contents are left as written.

## Timing
- Beat accepted at edge N: imem_we = 1 with imem_addr/imem_wdata valid in cycle N+1, for exactly one cycle per beat. Back-to-back beats give one write per cycle.
- State is HOLD in the cycle after the last accept. core_reset falls RST_HOLD cycles after HOLD entry.
- Minimum load-to-run latency: 1 + RST_HOLD cycles after the last accept.
- Halt: done rises, and core_reset rises, one cycle after the cycle in which pc == halt_pc.
- Timeout: timeout rises one cycle after the run_cycles-th RUN cycle.
- word_count updates one cycle after the accepting edge, aligned with imem_we.

## Configuration
- BOOT_WB_SIG_EN defined:
  - In each RUN cycle, sig ← {sig[30:0], sig[31]} ^ wb.
  - sig holds its value in DONE/TIMEOUT and clears on restart and on reset.
- BOOT_WB_SIG_EN undefined:
  - sig is tied to 0 and the signature register is not built.
  - All other behaviour is identical.

## Test plan
- Reset check: assert reset_n low mid-LOAD after 3 words → ld_ready = 0, word_count = 0, core_reset = 1, done = 0, timeout = 0 immediately (asynchronously).
- Multiply program:
  - Stimulus: load 8 words 3e800093, 00300113, 00000193, 00000213, 00220863, 001181b3, 00120213, ff5ff36f with ld_last on word 8; halt_pc = 0x20, run_cycles = 0.
  - Response: imem writes to addresses 0..7; word_count = 8; core_reset low 1 + RST_HOLD cycles after the last accept; wb reaches 3000; done = 1; timeout = 0.
- Timeout: same program, halt_pc = 0x400, run_cycles = 50 → timeout = 1 after exactly 50 RUN cycles, core_reset = 1, done = 0.
- Full memory: ADDR_W = 2, stream 6 words with no ld_last → exactly 4 accepted, ld_ready = 0 after the 4th accept, state reaches HOLD.
- Priority and restart:
  - run_cycles chosen so that the timeout cycle coincides with pc == halt_pc → done = 1, timeout = 0.
  - Then pulse restart → LOAD with word_count = 0, and a second load/run completes normally.
- Signature (BOOT_WB_SIG_EN defined): compare sig against the bench's reference model for the multiply program. Build without the macro → sig = 0 throughout.
